error_tracker_ring: RTL and testbench
=====================================

Name: error_tracker_ring

Overview:
- Parametrised successor to the one-shot SRAM error tracker. Captures multi-frame snapshots of equalizer errors, PRBS flags, bitstream and detector flags into on-chip SRAM.
- Adds a pre-trigger circular history, a programmable post-trigger window and a configurable frame count per entry.
- Readout uses a word-sliced debug port with a req/valid handshake.
- Sits beside the DSP backend and is driven by the JTAG debug register file.

Parameters:
- FRAME_BITS, 144, width of one SRAM row.
- FRAMES, 4, SRAM rows per snapshot entry (2..8).
- ADDR_BITS, 12, SRAM row address width; depth = 2^ADDR_BITS rows.
- WORD_BITS, 32, readout slice width.
- WORDS, ceil(FRAME_BITS/WORD_BITS), slices per row; the top slice is zero-padded in its LSBs.
- CNT_BITS, ADDR_BITS, width of the pre/post entry counters.

Ports:
- clk  in  1  capture/read clock
- rstb  in  1  async active-low reset
- entry_in  in  FRAMES*FRAME_BITS  concatenated snapshot; frame k = bits [(k+1)*FRAME_BITS-1 : k*FRAME_BITS]
- trigger  in  1  capture trigger, level-sampled
- arm  in  1  rising edge starts an acquisition from IDLE or DONE
- ring_mode  in  1  0 = one-shot from trigger; 1 = circular pre-trigger history
- post_entries  in  CNT_BITS  entries stored after the trigger (one-shot: total entries)
- rd_req  in  1  read request pulse
- rd_addr  in  ADDR_BITS  row to read
- rd_word  in  3  slice select, 0..WORDS-1
- rd_data  out  WORD_BITS  read slice
- rd_valid  out  1  rd_data valid pulse
- busy  out  1  high in ARMED or CAPTURE
- done  out  1  high in DONE
- wrapped  out  1  ring buffer wrapped before the trigger
- trig_row  out  ADDR_BITS  row of the first frame of the trigger entry
- last_row  out  ADDR_BITS  row of the last frame written

Behaviour:
- Reset: state=IDLE; all outputs 0; write pointer 0; SRAM contents undefined.
- Capacity: ENTRY_ROWS = FRAMES. MAX_ENTRIES = floor(2^ADDR_BITS / FRAMES). Unused top rows are never written.
- States: IDLE, ARMED, CAPTURE, DONE.
- IDLE: SRAM read-only. An arm rising edge clears wrapped, trig_row, last_row and the write pointer, then goes to ARMED.
- ARMED, ring_mode=0: waits for trigger=1, then goes to CAPTURE. The trigger entry is entry 0.
- ARMED, ring_mode=1:
  - Writes entries continuously; the pointer wraps to row 0 after MAX_ENTRIES entries and sets wrapped=1 (sticky).
  - trigger=1 sampled at an entry boundary marks that entry as the trigger entry, latches trig_row, then goes to CAPTURE.
- Entry write:
  - entry_in is latched into a holding register on the cycle the entry starts.
  - Frames 0..FRAMES-1 are written on FRAMES consecutive cycles, with WEB low each cycle.
  - The next entry starts on the following cycle, so throughput is one entry per FRAMES cycles.
  - trigger is sampled only at entry start; triggers mid-entry are ignored.
- CAPTURE:
  - Writes entries until post_entries have been written, counting the trigger entry.
  - One-shot: also stops on reaching MAX_ENTRIES. last_row is latched and the block goes to DONE.
  - post_entries=0 is treated as 1.
  - Ring: the post window overwrites the oldest history. The last stored entry ends just before the oldest surviving pre-trigger entry when the window is full.
- DONE: no writes; done=1. An arm edge restarts the acquisition as from IDLE.
- Read:
  - rd_req is accepted only in IDLE or DONE. Requests in ARMED/CAPTURE are dropped with no rd_valid.
  - The SRAM read is issued on the cycle of rd_req.
  - rd_data/rd_valid are registered 2 cycles after rd_req (SRAM latency 1 + mux register). rd_valid is a 1-cycle pulse.
  - Back-to-back rd_req, one per cycle, is supported and pipelined.
  - Slice w = row[(w+1)*WORD_BITS-1 : w*WORD_BITS]. The last slice is zero-padded in its LSBs. rd_word >= WORDS returns 0.
  - rd_data holds its value between pulses.
- Simultaneous arm and rd_req in DONE: arm wins and the read is dropped.
- Reset mid-capture: immediate return to IDLE with all outputs 0.
- SRAM: one instance of sram (ADR_BITS, DAT_BITS=FRAME_BITS) with CEB tied low and a single muxed address (write pointer while writing, rd_addr otherwise).

Test Plan:
- One-shot, FRAMES=4, post_entries=3: arm, trigger at cycle 10 -> 12 rows written; trig_row=0, last_row=11, done=1; reading row 5 word 0 returns frame 1 of entry 1, bits [31:0].
- Ring, ADDR_BITS=4 (MAX_ENTRIES=4), post_entries=2: arm, wait 6 entries, trigger -> wrapped=1; trig_row=8 (entry index 2); last_row=15; rows 0..3 hold the oldest surviving entry.
- Readout: rd_word=4 with FRAME_BITS=144 -> rd_data = {row[143:128], 16'h0000}. rd_word=5 -> 0. rd_valid asserts exactly 2 cycles after each rd_req over 5 back-to-back requests.
- Trigger asserted only on a mid-entry cycle -> ignored; capture starts at the next entry boundary where trigger=1.
- rd_req during CAPTURE -> no rd_valid. Re-arm from DONE -> flags cleared, new acquisition proceeds.
- rstb low during CAPTURE -> busy=0, done=0, state IDLE. After release, arm plus trigger captures normally from row 0.

Source files
------------

// File: rtl/error_tracker_ring_if.sv
// Read-side debug port of the error tracker: request/address/slice select in,
// registered slice data and a one-cycle valid pulse out.
interface error_tracker_ring_if #(
    parameter int ADDR_BITS = 12,
    parameter int WORD_BITS = 32
);
    logic                 rd_req;
    logic [ADDR_BITS-1:0] rd_addr;
    logic [2:0]           rd_word;
    logic [WORD_BITS-1:0] rd_data;
    logic                 rd_valid;

    modport master (
        output rd_req, rd_addr, rd_word,
        input  rd_data, rd_valid
    );

    modport slave (
        input  rd_req, rd_addr, rd_word,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/error_tracker_ring.sv
// Multi-frame SRAM error tracker with optional circular pre-trigger history,
// a programmable post-trigger window and a word-sliced debug readout.

// Single-port synchronous SRAM: write when web is low, registered read otherwise.
module sram #(
    parameter int ADR_BITS = 12,
    parameter int DAT_BITS = 144
) (
    input  logic                clk,
    input  logic                ceb,
    input  logic                web,
    input  logic [ADR_BITS-1:0] a,
    input  logic [DAT_BITS-1:0] d,
    output logic [DAT_BITS-1:0] q
);
    // NOTE: storage arrays carry no reset; clearing thousands of rows is not
    // possible in one cycle and the contents are undefined until written.
    logic [DAT_BITS-1:0] mem [2**ADR_BITS];

    // Array write or registered read on each enabled clock.
    always_ff @(posedge clk) begin
        if (!ceb) begin
            if (!web) begin
                mem[a] <= d;
            end else begin
                q <= mem[a];
            end
        end
    end
endmodule

module error_tracker_ring #(
    parameter int FRAME_BITS = 144,
    parameter int FRAMES     = 4,
    parameter int ADDR_BITS  = 12,
    parameter int WORD_BITS  = 32,
    parameter int WORDS      = (FRAME_BITS + WORD_BITS - 1) / WORD_BITS,
    parameter int CNT_BITS   = ADDR_BITS
) (
    input  logic                         clk,
    input  logic                         rstb,
    input  logic [FRAMES*FRAME_BITS-1:0] entry_in,
    input  logic                         trigger,
    input  logic                         arm,
    input  logic                         ring_mode,
    input  logic [CNT_BITS-1:0]          post_entries,
    error_tracker_ring_if.slave          rd_if,
    output logic                         busy,
    output logic                         done,
    output logic                         wrapped,
    output logic [ADDR_BITS-1:0]         trig_row,
    output logic [ADDR_BITS-1:0]         last_row
);
    localparam int MAX_ENTRIES = (2**ADDR_BITS) / FRAMES;
    localparam int FC_BITS     = $clog2(FRAMES);
    localparam int EXT_BITS    = WORDS * WORD_BITS;
    localparam int PAD_BITS    = EXT_BITS - FRAME_BITS;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t                state;
    logic                  arm_q;
    logic [ADDR_BITS-1:0]  wr_ptr;
    logic [ADDR_BITS-1:0]  entry_pos;
    logic [FC_BITS-1:0]    frame_cnt;
    logic [CNT_BITS-1:0]   cap_cnt;
    logic [FRAME_BITS-1:0] hold [FRAMES];

    logic                  arm_rise;
    logic                  idle_or_done;
    logic                  writing;
    logic                  entry_start;
    logic                  entry_end;
    logic                  last_entry_pos;
    logic [CNT_BITS-1:0]   post_eff;
    logic [CNT_BITS-1:0]   cap_next;
    logic                  cap_stop;

    logic [ADDR_BITS-1:0]  sram_addr;
    logic [FRAME_BITS-1:0] sram_d;
    logic [FRAME_BITS-1:0] sram_q;
    logic                  rd_acc;
    logic                  rd_v1;
    logic [2:0]            word_q;
    logic [EXT_BITS-1:0]   row_ext;
    logic [WORD_BITS-1:0]  slices [WORDS];
    logic [WORD_BITS-1:0]  slice_sel;
    logic [WORD_BITS-1:0]  rd_data_r;
    logic                  rd_valid_r;

    assign arm_rise       = arm & ~arm_q;
    assign idle_or_done   = (state == IDLE) || (state == DONE);
    assign writing        = (state == CAPTURE) || ((state == ARMED) && ring_mode);
    assign entry_start    = writing && (frame_cnt == '0);
    assign entry_end      = writing && (frame_cnt == FC_BITS'(FRAMES - 1));
    assign last_entry_pos = (entry_pos == ADDR_BITS'(MAX_ENTRIES - 1));
    assign post_eff       = (post_entries == '0) ? CNT_BITS'(1) : post_entries;
    assign cap_next       = cap_cnt + 1'b1;

    // The capture window closes when the requested count is reached, when a
    // one-shot run fills the array, or when a ring run would next overwrite
    // its own trigger entry.
    assign cap_stop = (state == CAPTURE) && entry_end &&
                      ((cap_next >= post_eff) ||
                       (!ring_mode && last_entry_pos) ||
                       (ring_mode && (cap_next == CNT_BITS'(MAX_ENTRIES))));

    assign busy = (state == ARMED) || (state == CAPTURE);
    assign done = (state == DONE);

    // Acquisition FSM with write pointer, frame/entry counters and status flags.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= IDLE;
            arm_q     <= 1'b0;
            wr_ptr    <= '0;
            entry_pos <= '0;
            frame_cnt <= '0;
            cap_cnt   <= '0;
            wrapped   <= 1'b0;
            trig_row  <= '0;
            last_row  <= '0;
        end else begin
            // NOTE: every register here uses <= so each update sees the values
            // from before this edge; a blocking = would leak new values into
            // later statements and no longer model flip-flops.
            arm_q <= arm;

            if (writing) begin
                if (entry_end) begin
                    frame_cnt <= '0;
                    if (last_entry_pos) begin
                        entry_pos <= '0;
                        wr_ptr    <= '0;
                        if (state == ARMED) begin
                            wrapped <= 1'b1;
                        end
                    end else begin
                        entry_pos <= entry_pos + 1'b1;
                        wr_ptr    <= wr_ptr + 1'b1;
                    end
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                    wr_ptr    <= wr_ptr + 1'b1;
                end
            end

            case (state)
                IDLE, DONE: begin
                    if (arm_rise) begin
                        state     <= ARMED;
                        wrapped   <= 1'b0;
                        trig_row  <= '0;
                        last_row  <= '0;
                        wr_ptr    <= '0;
                        entry_pos <= '0;
                        frame_cnt <= '0;
                        cap_cnt   <= '0;
                    end
                end
                ARMED: begin
                    if (ring_mode) begin
                        if (entry_start && trigger) begin
                            state    <= CAPTURE;
                            trig_row <= wr_ptr;
                            cap_cnt  <= '0;
                        end
                    end else if (trigger) begin
                        state    <= CAPTURE;
                        trig_row <= '0;
                        cap_cnt  <= '0;
                    end
                end
                CAPTURE: begin
                    if (entry_end) begin
                        cap_cnt <= cap_next;
                        if (cap_stop) begin
                            state    <= DONE;
                            last_row <= wr_ptr;
                        end
                    end
                end
            endcase
        end
    end

    // Snapshot holding register, loaded when an entry starts.
    always_ff @(posedge clk) begin
        if (entry_start) begin
            for (int k = 0; k < FRAMES; k++) begin
                hold[k] <= entry_in[k*FRAME_BITS +: FRAME_BITS];
            end
        end
    end

    // Frame 0 goes straight from the input so an entry takes exactly FRAMES cycles.
    assign sram_d    = (frame_cnt == '0) ? entry_in[FRAME_BITS-1:0] : hold[frame_cnt];
    assign sram_addr = writing ? wr_ptr : rd_if.rd_addr;
    assign rd_acc    = rd_if.rd_req && idle_or_done && !arm_rise;

    sram #(
        .ADR_BITS (ADDR_BITS),
        .DAT_BITS (FRAME_BITS)
    ) u_sram (
        .clk (clk),
        .ceb (1'b0),
        .web (~writing),
        .a   (sram_addr),
        .d   (sram_d),
        .q   (sram_q)
    );

    // Slice view of the read row; the top slice is left-aligned so its pad is in the LSBs.
    assign row_ext = EXT_BITS'(sram_q);

    for (genvar w = 0; w < WORDS; w++) begin : g_slice
        if (w == WORDS - 1) begin : g_top
            assign slices[w] = row_ext[w*WORD_BITS +: WORD_BITS] << PAD_BITS;
        end else begin : g_mid
            assign slices[w] = row_ext[w*WORD_BITS +: WORD_BITS];
        end
    end

    // Slice select; out-of-range selects read as zero.
    always_comb begin
        // NOTE: the default before the loop keeps every path assigned, so no
        // latch is inferred for slice_sel.
        slice_sel = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (word_q == 3'(w)) begin
                slice_sel = slices[w];
            end
        end
    end

    // Two-stage read pipeline: SRAM access, then registered slice mux.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rd_v1      <= 1'b0;
            word_q     <= '0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= '0;
        end else begin
            rd_v1      <= rd_acc;
            word_q     <= rd_if.rd_word;
            rd_valid_r <= rd_v1;
            if (rd_v1) begin
                rd_data_r <= slice_sel;
            end
        end
    end

    assign rd_if.rd_data  = rd_data_r;
    assign rd_if.rd_valid = rd_valid_r;
endmodule

// File: tb/tb_error_tracker_ring.sv
// Directed bench for error_tracker_ring: one-shot, ring, readout slicing,
// dropped reads, re-arm and mid-capture reset, with a read scoreboard.
module tb_error_tracker_ring;
    localparam int FB = 144;
    localparam int FR = 4;
    localparam int AB = 4;
    localparam int WB = 32;

    logic              clk = 1'b0;
    logic              rstb;
    logic [FR*FB-1:0]  entry_in;
    logic              trigger;
    logic              arm;
    logic              ring_mode;
    logic [AB-1:0]     post_entries;
    logic              busy, done, wrapped;
    logic [AB-1:0]     trig_row, last_row;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [FB-1:0] mem_m [16];
    logic [AB-1:0] ra [8];
    logic [2:0]    rw [8];
    logic [WB-1:0] exp_q [$];
    int            iss_q [$];

    error_tracker_ring_if #(.ADDR_BITS(AB), .WORD_BITS(WB)) rd_if ();

    error_tracker_ring #(
        .FRAME_BITS (FB),
        .FRAMES     (FR),
        .ADDR_BITS  (AB),
        .WORD_BITS  (WB),
        .CNT_BITS   (AB)
    ) dut (
        .clk          (clk),
        .rstb         (rstb),
        .entry_in     (entry_in),
        .trigger      (trigger),
        .arm          (arm),
        .ring_mode    (ring_mode),
        .post_entries (post_entries),
        .rd_if        (rd_if.slave),
        .busy         (busy),
        .done         (done),
        .wrapped      (wrapped),
        .trig_row     (trig_row),
        .last_row     (last_row)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [FB-1:0] frame(input int c, input int k);
        logic [31:0] cc;
        cc = 32'(c);
        return {16'hA000 | 16'(k), cc * 32'd3, ~cc, 32'h00AB_0000 | 32'(k), (cc << 8) + 32'(k)};
    endfunction

    function automatic logic [FR*FB-1:0] make_entry(input int c);
        logic [FR*FB-1:0] e;
        for (int k = 0; k < FR; k++) e[k*FB +: FB] = frame(c, k);
        return e;
    endfunction

    function automatic logic [WB-1:0] exp_slice(input logic [FB-1:0] row, input logic [2:0] w);
        if (w < 3'd4) return row[w*32 +: 32];
        if (w == 3'd4) return {row[143:128], 16'h0000};
        return '0;
    endfunction

    assign entry_in = make_entry(cyc);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_entry(input int pos, input int c);
        for (int k = 0; k < FR; k++) mem_m[pos*FR + k] = frame(c, k);
    endtask

    task automatic goto_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_done(input string tag, input int max_cyc, output int at);
        at = -1;
        for (int i = 0; i < max_cyc; i++) begin
            if (done) begin
                at = cyc;
                break;
            end
            @(negedge clk);
        end
        check({tag, " done"}, 64'(done), 64'd1);
    endtask

    // Back-to-back reads from ra/rw; expected slices and issue times go to the scoreboard.
    task automatic read_burst(input string tag, input int n, input bit accept);
        int pulses;
        int t0;
        pulses = 0;
        for (int t = 0; t < n + 5; t++) begin
            @(negedge clk);
            if (rd_if.rd_valid) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    check({tag, " unexpected"}, 64'(exp_q.size()), 64'd1);
                end else begin
                    t0 = iss_q.pop_front();
                    check({tag, " data"}, 64'(rd_if.rd_data), 64'(exp_q.pop_front()));
                    check({tag, " latency"}, 64'(t - t0), 64'd2);
                end
            end
            if (t < n) begin
                rd_if.rd_req  = 1'b1;
                rd_if.rd_addr = ra[t];
                rd_if.rd_word = rw[t];
                if (accept) begin
                    exp_q.push_back(exp_slice(mem_m[ra[t]], rw[t]));
                    iss_q.push_back(t);
                end
            end else begin
                rd_if.rd_req = 1'b0;
            end
        end
        check({tag, " pulses"}, 64'(pulses), accept ? 64'(n) : 64'd0);
        exp_q.delete();
        iss_q.delete();
    endtask

    initial begin
        int e, a, at, pulses;

        rstb = 1'b0; trigger = 1'b0; arm = 1'b0; ring_mode = 1'b0; post_entries = '0;
        rd_if.rd_req = 1'b0; rd_if.rd_addr = '0; rd_if.rd_word = '0;
        repeat (3) @(negedge clk);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst wrapped", 64'(wrapped), 64'd0);
        check("rst trig_row", 64'(trig_row), 64'd0);
        check("rst last_row", 64'(last_row), 64'd0);
        check("rst rd_valid", 64'(rd_if.rd_valid), 64'd0);
        check("rst rd_data", 64'(rd_if.rd_data), 64'd0);
        rstb = 1'b1;
        @(negedge clk);

        // One-shot, post_entries=3: three entries from the cycle after the trigger.
        post_entries = 4'd3; arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        check("os armed busy", 64'(busy), 64'd1);
        goto_cyc(10);
        e = cyc; trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        wait_done("os", 40, at);
        check("os done cycle", 64'(at), 64'(e + 13));
        check("os trig_row", 64'(trig_row), 64'd0);
        check("os last_row", 64'(last_row), 64'd11);
        check("os wrapped", 64'(wrapped), 64'd0);
        check("os busy", 64'(busy), 64'd0);
        for (int j = 0; j < 3; j++) model_entry(j, e + 1 + 4*j);
        ra[0] = 4'd5;  rw[0] = 3'd0;
        ra[1] = 4'd5;  rw[1] = 3'd4;
        ra[2] = 4'd5;  rw[2] = 3'd5;
        ra[3] = 4'd0;  rw[3] = 3'd1;
        ra[4] = 4'd11; rw[4] = 3'd3;
        read_burst("os rd", 5, 1'b1);

        // Ring mode, post_entries=2, re-armed from DONE.
        a = cyc; ring_mode = 1'b1; post_entries = 4'd2; arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        check("rearm busy", 64'(busy), 64'd1);
        check("rearm done", 64'(done), 64'd0);
        check("rearm last_row", 64'(last_row), 64'd0);
        goto_cyc(a + 7);
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        goto_cyc(a + 10);
        check("mid trig busy", 64'(busy), 64'd1);
        check("mid trig trig_row", 64'(trig_row), 64'd0);
        check("pre wrap wrapped", 64'(wrapped), 64'd0);
        goto_cyc(a + 20);
        check("post wrap wrapped", 64'(wrapped), 64'd1);
        check("post wrap done", 64'(done), 64'd0);
        goto_cyc(a + 25);
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        ra[0] = 4'd1; rw[0] = 3'd0;
        ra[1] = 4'd2; rw[1] = 3'd0;
        read_burst("cap rd", 2, 1'b0);
        wait_done("ring", 40, at);
        check("ring wrapped", 64'(wrapped), 64'd1);
        check("ring trig_row", 64'(trig_row), 64'd8);
        check("ring last_row", 64'(last_row), 64'd15);
        for (int j = 0; j < 8; j++) model_entry(j % 4, a + 1 + 4*j);
        ra[0] = 4'd0;  rw[0] = 3'd0;
        ra[1] = 4'd3;  rw[1] = 3'd2;
        ra[2] = 4'd8;  rw[2] = 3'd1;
        ra[3] = 4'd15; rw[3] = 3'd4;
        ra[4] = 4'd5;  rw[4] = 3'd0;
        read_burst("ring rd", 5, 1'b1);

        // Arm and read together in DONE: arm wins, read dropped.
        ring_mode = 1'b0; post_entries = '0; arm = 1'b1;
        rd_if.rd_req = 1'b1; rd_if.rd_addr = 4'd0; rd_if.rd_word = 3'd0;
        @(negedge clk);
        arm = 1'b0; rd_if.rd_req = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rd_if.rd_valid) pulses++;
        end
        check("arm vs rd pulses", 64'(pulses), 64'd0);
        check("arm vs rd busy", 64'(busy), 64'd1);

        // Reset in the middle of a capture.
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        repeat (2) @(negedge clk);
        rstb = 1'b0;
        #1;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst done", 64'(done), 64'd0);
        check("midrst wrapped", 64'(wrapped), 64'd0);
        check("midrst last_row", 64'(last_row), 64'd0);
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);

        // Post-reset capture with post_entries=0 (one entry).
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        e = cyc; trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        wait_done("post0", 40, at);
        check("post0 done cycle", 64'(at), 64'(e + 5));
        check("post0 trig_row", 64'(trig_row), 64'd0);
        check("post0 last_row", 64'(last_row), 64'd3);
        model_entry(0, e + 1);
        ra[0] = 4'd0; rw[0] = 3'd0;
        ra[1] = 4'd3; rw[1] = 3'd4;
        ra[2] = 4'd2; rw[2] = 3'd3;
        read_burst("post0 rd", 3, 1'b1);

        // One-shot with post_entries beyond capacity stops at MAX_ENTRIES.
        post_entries = 4'd7; arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        e = cyc; trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        wait_done("osmax", 60, at);
        check("osmax done cycle", 64'(at), 64'(e + 17));
        check("osmax last_row", 64'(last_row), 64'd15);
        check("osmax wrapped", 64'(wrapped), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
